// File: rtl/fsub_seq.sv
// fsub_seq: area-reduced multi-cycle IEEE-754 single-precision subtractor, y = x1 - x2.
// One operand is aligned one bit per cycle, the sum is normalised one bit per cycle,
// and a single 27-bit adder does the add/subtract. Operands are captured on start.
module fsub_seq #(
   parameter int unsigned MAX_ALIGN = 31
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   output logic        busy,
   output logic        done,
   output logic [31:0] y,
   output logic        ovf
);

   localparam int unsigned CW = $clog2(MAX_ALIGN + 1);
   localparam int unsigned SW = 25 + MAX_ALIGN;

   typedef enum logic [2:0] {
      StIdle, StUnpack, StAlign, StAdd, StNorm, StRound, StDone
   } state_t;

   state_t          state_q;
   logic [31:0]     x1_q, x2_q;
   logic [24:0]     ms_q;
   logic [7:0]      exp_q;
   logic            ss_q;
   logic [SW-1:0]   mia_q;
   logic [CW-1:0]   cnt_q;
   logic [26:0]     mye_q;
   logic            sticky_q;

   logic [7:0]      e1, e2, e1a, e2a, de;
   logic [24:0]     m1f, m2f;
   logic            s1, s2e, op_add, pick1, special;
   logic [CW-1:0]   de_c;
   logic [31:0]     spec_y;
   logic [26:0]     mia_top, sum;
   logic            need_now, need_next;
   logic            inc;
   logic [24:0]     rnd;
   logic [7:0]      re;
   logic [22:0]     rm;
   logic            rs;

   // Operand unpacking, larger-operand selection and special-value result
   always_comb begin
      e1      = x1_q[30:23];
      e2      = x2_q[30:23];
      e1a     = (e1 == 8'd0) ? 8'd1 : e1;
      e2a     = (e2 == 8'd0) ? 8'd1 : e2;
      m1f     = {1'b0, (e1 != 8'd0), x1_q[22:0]};
      m2f     = {1'b0, (e2 != 8'd0), x2_q[22:0]};
      s1      = x1_q[31];
      s2e     = ~x2_q[31];
      op_add  = (s1 == s2e);
      // Equal exponents and equal mantissas pick x2
      pick1   = (e1a > e2a) || ((e1a == e2a) && (m1f > m2f));
      de      = pick1 ? (e1a - e2a) : (e2a - e1a);
      de_c    = ({24'd0, de} > MAX_ALIGN) ? CW'(MAX_ALIGN) : CW'(de);
      special = (e1 == 8'hFF) || (e2 == 8'hFF);
      spec_y  = 32'd0;
      if ((e1 == 8'hFF) && (e2 == 8'hFF)) begin
         if (x2_q[22:0] != 23'd0)      spec_y = {s2e, 8'hFF, 1'b1, x2_q[21:0]};
         else if (x1_q[22:0] != 23'd0) spec_y = {s1, 8'hFF, 1'b1, x1_q[21:0]};
         else if (op_add)              spec_y = {s1, 8'hFF, 23'd0};
         else                          spec_y = 32'hFFC00000;
      end else if (e1 == 8'hFF) begin
         spec_y = {s1, 8'hFF, (x1_q[22:0] != 23'd0), x1_q[21:0]};
      end else begin
         spec_y = {s2e, 8'hFF, (x2_q[22:0] != 23'd0), x2_q[21:0]};
      end
   end

   // Shared adder, normalisation decisions and round-to-nearest-even result
   always_comb begin
      mia_top   = mia_q[SW-1 -: 27];
      sum       = op_add ? ({ms_q, 2'b00} + mia_top) : ({ms_q, 2'b00} - mia_top);
      need_now  = (mye_q != 27'd0) && !mye_q[25] && (exp_q > 8'd1);
      // After one more left shift: the value stays nonzero, bit24 becomes bit25
      need_next = !mye_q[24] && (exp_q > 8'd2);
      inc       = mye_q[1] & (mye_q[0] | (sticky_q ? op_add : mye_q[2]));
      rnd       = mye_q[26:2] + {24'd0, inc};
      if (rnd[24]) begin
         re = exp_q + 8'd1;
         rm = 23'd0;
      end else if (!rnd[23]) begin
         // No hidden bit: denormal or exact zero
         re = 8'd0;
         rm = rnd[22:0];
      end else begin
         re = exp_q;
         rm = rnd[22:0];
      end
      rs = (rnd == 25'd0) ? (s1 & s2e) : ss_q;
   end

   // Sequencer: state, datapath registers and registered handshake/result outputs
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= StIdle;
         busy     <= 1'b0;
         done     <= 1'b0;
         y        <= 32'd0;
         ovf      <= 1'b0;
         x1_q     <= 32'd0;
         x2_q     <= 32'd0;
         ms_q     <= 25'd0;
         exp_q    <= 8'd0;
         ss_q     <= 1'b0;
         mia_q    <= '0;
         cnt_q    <= '0;
         mye_q    <= 27'd0;
         sticky_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  x1_q    <= x1;
                  x2_q    <= x2;
                  busy    <= 1'b1;
                  state_q <= StUnpack;
               end
            end
            StUnpack: begin
               if (special) begin
                  y       <= spec_y;
                  ovf     <= 1'b0;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_q <= StDone;
               end else begin
                  ms_q    <= pick1 ? m1f : m2f;
                  exp_q   <= pick1 ? e1a : e2a;
                  ss_q    <= pick1 ? s1 : s2e;
                  mia_q   <= {(pick1 ? m2f : m1f), {MAX_ALIGN{1'b0}}};
                  cnt_q   <= de_c;
                  state_q <= (de_c == '0) ? StAdd : StAlign;
               end
            end
            StAlign: begin
               mia_q <= mia_q >> 1;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CW'(1)) state_q <= StAdd;
            end
            StAdd: begin
               mye_q    <= sum;
               sticky_q <= |mia_q[SW-28:0];
               state_q  <= StNorm;
            end
            StNorm: begin
               if (mye_q[26]) begin
                  if (exp_q == 8'd254) begin
                     // Overflow: pattern rounds to nothing and packs as infinity
                     exp_q    <= 8'hFF;
                     mye_q    <= {2'b01, 25'd0};
                     sticky_q <= 1'b0;
                  end else begin
                     exp_q    <= exp_q + 8'd1;
                     mye_q    <= {1'b0, mye_q[26:1]};
                     sticky_q <= sticky_q | mye_q[0];
                  end
                  state_q <= StRound;
               end else if (need_now) begin
                  mye_q <= {mye_q[25:0], 1'b0};
                  exp_q <= exp_q - 8'd1;
                  if (!need_next) state_q <= StRound;
               end else begin
                  state_q <= StRound;
               end
            end
            StRound: begin
               y       <= {rs, re, rm};
               ovf     <= (re == 8'hFF);
               done    <= 1'b1;
               busy    <= 1'b0;
               state_q <= StDone;
            end
            StDone: begin
               done    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fsub_seq.sv
// tb_fsub_seq: directed vector table plus hand-written reset/handshake sequences.
module tb_fsub_seq;

   logic        clk;
   logic        rstn;
   logic        start;
   logic [31:0] x1, x2;
   logic        busy, done, ovf;
   logic [31:0] y;

   int n_chk  = 0;
   int n_pass = 0;

   fsub_seq #(.MAX_ALIGN(31)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .start (start),
      .x1    (x1),
      .x2    (x2),
      .busy  (busy),
      .done  (done),
      .y     (y),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ey;
      logic        eovf;
      int          elat;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Issue one op once the unit is idle; lat counts cycles from acceptance to done
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic busy1, output logic busyd);
      @(negedge clk);
      while (busy || done) @(negedge clk);
      x1    = a;
      x2    = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      x1    = $urandom;
      x2    = $urandom;
      busy1 = busy;
      lat   = 1;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      busyd = busy;
   endtask

   initial begin
      int   lat;
      int   ndone;
      logic b1, bd;

      vecs[0]  = '{32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 6};
      vecs[1]  = '{32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 5};
      vecs[2]  = '{32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 5};
      vecs[3]  = '{32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 5};
      vecs[4]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 5};
      vecs[5]  = '{32'h7F800000, 32'h7F800000, 32'hFFC00000, 1'b0, 2};
      vecs[6]  = '{32'h3F800000, 32'h7FA00000, 32'hFFE00000, 1'b0, 2};
      vecs[7]  = '{32'h4C000000, 32'h3F800000, 32'h4C000000, 1'b0, 30};
      vecs[8]  = '{32'h00800000, 32'h00400000, 32'h00400000, 1'b0, 5};
      vecs[9]  = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 36};
      vecs[10] = '{32'h3F800000, 32'h7F800000, 32'hFF800000, 1'b0, 2};
      vecs[11] = '{32'h7F800001, 32'h3F800000, 32'h7FC00001, 1'b0, 2};
      vecs[12] = '{32'h3F800000, 32'h3F7FFFFF, 32'h33800000, 1'b0, 29};
      vecs[13] = '{32'h3F800001, 32'hB3800000, 32'h3F800002, 1'b0, 29};

      rstn  = 1'b0;
      start = 1'b0;
      x1    = 32'd0;
      x2    = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_y", y, 32'd0);
      check("reset_ovf", {31'd0, ovf}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 14; i++) begin
         run_op(vecs[i].a, vecs[i].b, lat, b1, bd);
         check($sformatf("v%0d_y", i), y, vecs[i].ey);
         check($sformatf("v%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].eovf});
         check($sformatf("v%0d_lat", i), lat, vecs[i].elat);
         check($sformatf("v%0d_busy_after_accept", i), {31'd0, b1}, 32'd1);
         check($sformatf("v%0d_busy_at_done", i), {31'd0, bd}, 32'd0);
      end

      // Reset in the middle of alignment aborts without a done pulse
      @(negedge clk);
      while (busy || done) @(negedge clk);
      x1    = 32'h4B800000;
      x2    = 32'h3F800000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_y", y, 32'd0);
      check("abort_ovf", {31'd0, ovf}, 32'd0);
      ndone = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      check("abort_no_done", ndone, 0);
      run_op(32'h4B800000, 32'h3F800000, lat, b1, bd);
      check("reissue_y", y, 32'h4B7FFFFF);
      check("reissue_lat", lat, 29);

      // start held high through the whole op, operands changing every cycle
      @(negedge clk);
      while (busy || done) @(negedge clk);
      x1    = 32'h40400000;
      x2    = 32'h3F800000;
      start = 1'b1;
      @(posedge clk);
      #1;
      lat   = 1;
      ndone = 0;
      while (!done && lat < 100) begin
         x1 = 32'h7F800000 ^ $urandom_range(0, 255);
         x2 = $urandom;
         @(posedge clk);
         #1;
         lat++;
      end
      check("held_start_y", y, 32'h40000000);
      check("held_start_lat", lat, 6);
      // Still in the done cycle: set up the back-to-back op, start remains high
      x1 = 32'h3F800000;
      x2 = 32'hBF800000;
      @(posedge clk);
      #1;
      check("done_single_pulse", {31'd0, done}, 32'd0);
      check("idle_after_done", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b_accepted", {31'd0, busy}, 32'd1);
      lat = 1;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) ndone++;
      end
      check("b2b_y", y, 32'h40000000);
      check("b2b_lat", lat, 5);
      @(posedge clk);
      #1;
      if (done) ndone++;
      check("b2b_one_done", ndone, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
